// File: rtl/sad_ctrl_if.sv
// -----------------------------------------------------------------------------
// sad_ctrl_if
//   Bundles the start request, the datapath control strobes, the datapath
//   status flag and the progress/status outputs of the SAD control FSM.
//
//   master : the controller (sad_ctrl) side
//            in : go, i_lt_256 [, abort]
//            out: i_inc, i_clr, sum_clr, sum_ld, sadreg_clr, sadreg_ld,
//                 cand_idx, busy, done [, aborted]
//   slave  : the datapath / requester side (directions mirrored)
//
//   Optional macro SAD_CTRL_ABORT_EN adds abort (to controller) and
//   aborted (from controller).
// -----------------------------------------------------------------------------
interface sad_ctrl_if #(
  parameter int CAND_W = 4
);
  logic              go;
  logic              i_lt_256;
  logic              i_inc;
  logic              i_clr;
  logic              sum_clr;
  logic              sum_ld;
  logic              sadreg_clr;
  logic              sadreg_ld;
  logic [CAND_W-1:0] cand_idx;
  logic              busy;
  logic              done;
`ifdef SAD_CTRL_ABORT_EN
  logic              abort;
  logic              aborted;

  modport master (
    input  go, i_lt_256, abort,
    output i_inc, i_clr, sum_clr, sum_ld, sadreg_clr, sadreg_ld,
           cand_idx, busy, done, aborted
  );
  modport slave (
    output go, i_lt_256, abort,
    input  i_inc, i_clr, sum_clr, sum_ld, sadreg_clr, sadreg_ld,
           cand_idx, busy, done, aborted
  );
`else
  modport master (
    input  go, i_lt_256,
    output i_inc, i_clr, sum_clr, sum_ld, sadreg_clr, sadreg_ld,
           cand_idx, busy, done
  );
  modport slave (
    output go, i_lt_256,
    input  i_inc, i_clr, sum_clr, sum_ld, sadreg_clr, sadreg_ld,
           cand_idx, busy, done
  );
`endif
endinterface

// File: rtl/sad_ctrl.sv
// -----------------------------------------------------------------------------
// sad_ctrl
//   Control FSM sitting directly upstream of the SAD datapath. One go runs
//   N_CAND candidate blocks; each candidate accumulates 256 |A-B| terms into
//   the datapath sum register and then stores the sum into the SAD register.
//   A token shift register (depth PIPE_D = 1 + MEM_LAT) delays each element
//   increment so that sum_ld lines up with the registered A/B address plus
//   the memory read latency.
//
//   Ports
//     clk  in  rising-edge clock
//     rst  in  synchronous active-high reset (aborts a run, no done)
//     bus  sad_ctrl_if.master:
//       go, i_lt_256              in
//       i_inc, i_clr              element counter increment / clear
//       sum_clr, sum_ld           sum register clear / accumulate
//       sadreg_clr, sadreg_ld     SAD register clear / load from sum
//       cand_idx                  candidate in progress / just stored
//       busy                      high in every state except idle
//       done                      1-cycle pulse after the last store
//
//   Optional feature macro: SAD_CTRL_ABORT_EN
//     adds bus.abort (in) and bus.aborted (out). abort outside idle returns
//     the FSM to idle next cycle, flushes the token pipe and pulses aborted;
//     the aborted run never produces done or another sadreg_ld.
// -----------------------------------------------------------------------------
module sad_ctrl #(
  parameter int N_CAND  = 1,
  parameter int CAND_W  = 4,
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  sad_ctrl_if.master  bus
);

  localparam int                PIPE_D    = MEM_LAT + 1;
  localparam logic [CAND_W-1:0] LAST_CAND = CAND_W'(N_CAND - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_DRAIN,
    S_STORE,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PIPE_D-1:0] r_tok_p;      // bit 0 = newest token, MSB drives sum_ld
  logic              w_tok_in;
  logic              w_tok_pend;
  logic [CAND_W-1:0] r_cand;
  logic              w_cand_clr;
  logic              w_cand_inc;
  logic              w_abort;

  // Tokens still in flight behind the one currently at the output. The
  // output token is consumed this cycle, so once nothing sits behind it the
  // sum register will be final after this edge and the store can follow.
  generate
    if (PIPE_D > 1) begin : g_pend
      assign w_tok_pend = |r_tok_p[PIPE_D-2:0];
    end else begin : g_nopend
      assign w_tok_pend = 1'b0;
    end
  endgenerate

`ifdef SAD_CTRL_ABORT_EN
  logic r_aborted;
  assign w_abort     = bus.abort && (r_state != S_IDLE);
  assign bus.aborted = r_aborted;
`else
  assign w_abort = 1'b0;
`endif

  assign bus.sum_ld   = r_tok_p[PIPE_D-1];
  assign bus.cand_idx = r_cand;

  // ---- state / token pipe / candidate index registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tok_p <= '0;
      r_cand  <= '0;
`ifdef SAD_CTRL_ABORT_EN
      r_aborted <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_abort) begin
        r_tok_p <= '0;
      end else begin
        r_tok_p <= (r_tok_p << 1) | PIPE_D'(w_tok_in);
      end
      if (w_cand_clr) begin
        r_cand <= '0;
      end else if (w_cand_inc) begin
        r_cand <= r_cand + 1'b1;
      end
`ifdef SAD_CTRL_ABORT_EN
      r_aborted <= w_abort;
`endif
    end
  end

  // ---- next state and datapath strobes ----
  always_comb begin
    w_state_nxt    = r_state;
    w_tok_in       = 1'b0;
    w_cand_clr     = 1'b0;
    w_cand_inc     = 1'b0;
    bus.i_inc      = 1'b0;
    bus.i_clr      = 1'b0;
    bus.sum_clr    = 1'b0;
    bus.sadreg_clr = 1'b0;
    bus.sadreg_ld  = 1'b0;
    bus.done       = 1'b0;
    bus.busy       = (r_state != S_IDLE);

    case (r_state)
      S_IDLE: begin
        if (bus.go) begin
          bus.sadreg_clr = 1'b1;
          w_cand_clr     = 1'b1;
          w_state_nxt    = S_INIT;
        end
      end
      S_INIT: begin
        bus.i_clr   = 1'b1;
        bus.sum_clr = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        bus.i_inc = bus.i_lt_256;
        w_tok_in  = bus.i_lt_256;
        if (!bus.i_lt_256) begin
          // With a single-stage pipe nothing is left to drain here.
          w_state_nxt = w_tok_pend ? S_DRAIN : S_STORE;
        end
      end
      S_DRAIN: begin
        if (!w_tok_pend) begin
          w_state_nxt = S_STORE;
        end
      end
      S_STORE: begin
        bus.sadreg_ld = 1'b1;
        if (r_cand < LAST_CAND) begin
          w_cand_inc  = 1'b1;
          w_state_nxt = S_INIT;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        bus.done    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // An abort wins over everything the current state would do next.
    if (w_abort) begin
      w_state_nxt   = S_IDLE;
      w_cand_inc    = 1'b0;
      bus.sadreg_ld = 1'b0;
      bus.done      = 1'b0;
    end
  end

endmodule

// File: tb/tb_sad_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sad_ctrl
//   Two controllers side by side, each with its own datapath + A/B memory
//   model:  u[0]: N_CAND=3, MEM_LAT=1   u[1]: N_CAND=1, MEM_LAT=0.
//   Expected control outputs per cycle come from a timeline computed from
//   the run start (INIT, 256 increments, loads delayed by PIPE_D, store,
//   done); expected SADs are summed directly from the memory contents.
// -----------------------------------------------------------------------------
module tb_sad_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       go_v [2];
  logic [7:0] obs_v [2];     // {i_inc,i_clr,sum_clr,sum_ld,sadreg_clr,sadreg_ld,busy,done}
  logic [3:0] obs_cand [2];
  logic [16:0] obs_sad [2];
  logic [7:0] mem_a [0:1023];
  logic [7:0] mem_b [0:1023];
  int         exp_sad [2][3];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cur_t   = 0;
`ifdef SAD_CTRL_ABORT_EN
  logic       abort_v [2];
  logic       obs_ab [2];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int ML = (g == 0) ? 1 : 0;
    localparam int NC = (g == 0) ? 3 : 1;

    sad_ctrl_if #(.CAND_W(4)) u_if ();
    sad_ctrl #(.N_CAND(NC), .CAND_W(4), .MEM_LAT(ML)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.master)
    );

    logic [8:0]  dp_cnt;
    logic [9:0]  dp_addr;
    logic [16:0] dp_sum;
    logic [16:0] dp_sad;
    logic [15:0] ab_now;
    logic [15:0] ab_use;
    logic [7:0]  dif;

    assign u_if.go       = go_v[g];
    assign u_if.i_lt_256 = (dp_cnt < 9'd256);
`ifdef SAD_CTRL_ABORT_EN
    assign u_if.abort    = abort_v[g];
    assign obs_ab[g]     = u_if.aborted;
`endif
    assign ab_now = {mem_a[dp_addr], mem_b[dp_addr]};
    if (ML == 0) begin : g_l0
      assign ab_use = ab_now;
    end else begin : g_l1
      always_ff @(posedge clk) ab_use <= ab_now;
    end
    assign dif = (ab_use[15:8] > ab_use[7:0]) ? ab_use[15:8] - ab_use[7:0]
                                              : ab_use[7:0] - ab_use[15:8];

    always_ff @(posedge clk) begin
      dp_addr <= {u_if.cand_idx[1:0], dp_cnt[7:0]};
      if (u_if.i_clr) dp_cnt <= '0;
      else if (u_if.i_inc) dp_cnt <= dp_cnt + 9'd1;
      if (u_if.sum_clr) dp_sum <= '0;
      else if (u_if.sum_ld) dp_sum <= dp_sum + {9'd0, dif};
      if (u_if.sadreg_clr) dp_sad <= '0;
      else if (u_if.sadreg_ld) dp_sad <= dp_sum;
    end

    assign obs_v[g]    = {u_if.i_inc, u_if.i_clr, u_if.sum_clr, u_if.sum_ld,
                          u_if.sadreg_clr, u_if.sadreg_ld, u_if.busy, u_if.done};
    assign obs_cand[g] = u_if.cand_idx;
    assign obs_sad[g]  = dp_sad;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s t=%0d: got %0h want %0h", tag, cur_t, got, want);
    end
  endtask

  // Expected control vector t cycles after go was sampled in idle (t=0).
  function automatic logic [7:0] exp_vec(input int t, input int d, input int n, input logic go);
    int P, k, r;
    logic [7:0] v;
    P = 258 + d;
    v = '0;
    if (t == 0) return go ? 8'b0000_1000 : 8'b0;
    k = (t - 1) / P;
    r = (t - 1) % P;
    if (k < n) begin
      v[1] = 1'b1;
      if (r == 0) begin v[6] = 1'b1; v[5] = 1'b1; end
      if (r >= 1 && r <= 256) v[7] = 1'b1;
      if (r >= 1 + d && r <= 256 + d) v[4] = 1'b1;
      if (r == 257 + d) v[2] = 1'b1;
    end else if (k == n && r == 0) begin
      v[1] = 1'b1;
      v[0] = 1'b1;
    end else begin
      v[3] = go;
    end
    return v;
  endfunction

  function automatic int sad_of(input int k);
    int s, a, b;
    s = 0;
    for (int j = 0; j < 256; j++) begin
      a = int'(mem_a[k*256 + j]);
      b = int'(mem_b[k*256 + j]);
      s += (a > b) ? a - b : b - a;
    end
    return s;
  endfunction

  task automatic fill_mem(input int inst, input int n, input int mode);
    for (int i = 0; i < n * 256; i++) begin
      mem_a[i] = (mode == 1) ? 8'd255 : 8'($urandom_range(0, 255));
      mem_b[i] = (mode == 1) ? 8'd0   : 8'($urandom_range(0, 255));
    end
    for (int k = 0; k < n; k++) exp_sad[inst][k] = sad_of(k);
  endtask

  task automatic run_check(input int inst, input int d, input int n, input int ncyc,
                           input int go_len, input int extra_go, input int rst_at,
                           input int prev_cand, input int exp_done);
    int P, tt, k, n_done, sad_k;
    logic second, sad_pend;
    logic [7:0] ev;
    int ec;
    P = 258 + d;
    n_done = 0;
    sad_pend = 1'b0;
    sad_k = 0;
    for (int t = 0; t < ncyc; t++) begin
      @(posedge clk);
      #1;
      cur_t = t;
      if (sad_pend) begin
        chk("sad_value", 32'(obs_sad[inst]), 32'(exp_sad[inst][sad_k]));
        sad_pend = 1'b0;
      end
      go_v[inst] = (t < go_len) || (t == extra_go);
      rst        = (t == rst_at);
      @(negedge clk);
      second = (go_len > P + 2) && (t >= P + 2);
      tt     = second ? t - (P + 2) : t;
      if (rst_at >= 0 && t > rst_at) begin
        ev = '0;
        ec = 0;
      end else begin
        ev = exp_vec(tt, d, n, go_v[inst]);
        k  = (tt == 0) ? 0 : (tt - 1) / P;
        if (tt == 0) ec = second ? n - 1 : prev_cand;
        else         ec = (k < n) ? k : n - 1;
      end
      chk("ctl", 32'(obs_v[inst]), 32'(ev));
      chk("cand_idx", 32'(obs_cand[inst]), 32'(ec));
      if (obs_v[inst][0]) n_done++;
      if (ev[2]) begin
        sad_pend = 1'b1;
        sad_k    = ec;
      end
    end
    @(posedge clk);
    #1;
    go_v[inst] = 1'b0;
    rst        = 1'b0;
    chk("done_count", 32'(n_done), 32'(exp_done));
  endtask

  initial begin
    go_v[0] = 1'b0;
    go_v[1] = 1'b0;
`ifdef SAD_CTRL_ABORT_EN
    abort_v[0] = 1'b0;
    abort_v[1] = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_ctl", 32'(obs_v[i]), 32'd0);
      chk("reset_cand", 32'(obs_cand[i]), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Three candidates, MEM_LAT=1, a stray go mid-run that must be ignored.
    fill_mem(0, 3, 0);
    run_check(0, 2, 3, 3 * 260 + 6, 1, 100, -1, 0, 1);

    // Single candidate, MEM_LAT=0, A=255 / B=0 everywhere.
    fill_mem(1, 1, 1);
    chk("sad_const", 32'(exp_sad[1][0]), 32'd65280);
    run_check(1, 1, 1, 259 + 6, 1, -1, -1, 0, 1);

    // go held high through the first done: back-to-back second run.
    fill_mem(1, 1, 0);
    run_check(1, 1, 1, (259 + 2) + 259 + 6, 259 + 3, -1, -1, 0, 2);

    // Reset in the middle of a run, then a clean full run.
    fill_mem(0, 3, 0);
    run_check(0, 2, 3, 200, 1, -1, 150, 2, 0);
    fill_mem(0, 3, 0);
    run_check(0, 2, 3, 3 * 260 + 6, 1, -1, -1, 0, 1);

`ifdef SAD_CTRL_ABORT_EN
    // Abort at cycle 50 of a run.
    begin
      int sum_ld_late;
      int done_seen;
      sum_ld_late = 0;
      done_seen   = 0;
      for (int t = 0; t < 80; t++) begin
        @(posedge clk);
        #1;
        cur_t = t;
        go_v[0]    = (t == 0);
        abort_v[0] = (t == 50);
        @(negedge clk);
        chk("abort_ctl", 32'(obs_v[0]), 32'((t > 50) ? 8'd0 : exp_vec(t, 2, 3, go_v[0])));
        chk("aborted", 32'(obs_ab[0]), 32'(t == 51));
        if (t > 51 && obs_v[0][4]) sum_ld_late++;
        if (obs_v[0][0]) done_seen++;
      end
      @(posedge clk);
      #1;
      abort_v[0] = 1'b0;
      go_v[0]    = 1'b0;
      chk("abort_sum_ld", 32'(sum_ld_late), 32'd0);
      chk("abort_done", 32'(done_seen), 32'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
